// File: rtl/exec_control.sv
// Multi-cycle execute unit behind the instruction fetch ROM: latch, decode and execute one
// instruction on a private six-entry register file, then signal done or branch to fetch.
module exec_control #(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ARG_NUM  = 2,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  localparam int INSTR_W = OP_SIZE + ARG_NUM * ARG_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic [DATA_W-1:0]   din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                done,
  output logic                branch,
  output logic [ADDR_W-1:0]   branchaddress,
  output logic                busy,
  output logic                carry,
  input  logic [ARG_SIZE-1:0] dbg_sel,
  output logic [DATA_W-1:0]   dbg_data
);

  localparam logic [OP_SIZE-1:0] OP_LOAD = OP_SIZE'(4'b0000);
  localparam logic [OP_SIZE-1:0] OP_MOVE = OP_SIZE'(4'b0001);
  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(4'b0010);
  localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(4'b0011);
  localparam logic [OP_SIZE-1:0] OP_BR   = OP_SIZE'(4'b1000);
  localparam int                 RF_N    = 2 ** ARG_SIZE;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LOAD, S_MOVE, S_ALU_A, S_ALU_G, S_WB, S_BRANCH, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_a, r_g;
  logic                r_carry;
  logic [DATA_W-1:0]   r_regs [1:6];

  logic [DATA_W-1:0]   w_rf [0:RF_N-1];
  logic [OP_SIZE-1:0]  w_op;
  logic [ARG_SIZE-1:0] w_rx, w_ry;
  logic [DATA_W-1:0]   w_rx_val, w_ry_val;
  logic                w_wr_en;
  logic [DATA_W-1:0]   w_wr_data;
  logic [DATA_W:0]     w_sum;

  function automatic logic [DATA_W:0] alu_add(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Operands always come from the latched IR, never the live ROM word.
  assign w_op = r_ir[INSTR_W-1 -: OP_SIZE];
  assign w_rx = r_ir[2*ARG_SIZE-1 -: ARG_SIZE];
  assign w_ry = r_ir[ARG_SIZE-1:0];

  // NA (0) and PC (7) have no storage and read as zero.
  always_comb begin
    for (int i = 0; i < RF_N; i++) w_rf[i] = '0;
    for (int i = 1; i <= 6; i++) w_rf[i] = r_regs[i];
  end

  assign w_rx_val = w_rf[w_rx];
  assign w_ry_val = w_rf[w_ry];
  assign w_sum    = alu_add(r_a, w_ry_val);
  assign dbg_data = w_rf[dbg_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_wr_en   = 1'b0;
    w_wr_data = r_g;
    case (r_state)
      S_FETCH:  if (run) w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_LOAD:        w_next = S_LOAD;
          OP_MOVE:        w_next = S_MOVE;
          OP_ADD, OP_XOR: w_next = S_ALU_A;
          OP_BR:          w_next = S_BRANCH;
          default:        w_next = S_DONE;
        endcase
      end
      S_LOAD: begin
        if (din_valid) begin
          w_wr_en   = 1'b1;
          w_wr_data = din;
          w_next    = S_DONE;
        end
      end
      S_MOVE: begin
        w_wr_en   = 1'b1;
        w_wr_data = w_ry_val;
        w_next    = S_DONE;
      end
      S_ALU_A:  w_next = S_ALU_G;
      S_ALU_G:  w_next = S_WB;
      S_WB: begin
        w_wr_en   = 1'b1;
        w_wr_data = r_g;
        w_next    = S_DONE;
      end
      S_BRANCH: w_next = S_FETCH;
      S_DONE:   w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
      r_carry <= 1'b0;
    end else begin
      if (r_state == S_FETCH && run) r_ir <= instruction;
      if (r_state == S_ALU_A) r_a <= w_rx_val;
      if (r_state == S_ALU_G) begin
        if (w_op == OP_ADD) {r_carry, r_g} <= w_sum;
        else                r_g <= r_a ^ w_ry_val;
      end
    end
  end

  // Writes addressed to NA or PC match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 6; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i <= 6; i++)
        if (w_wr_en && w_rx == ARG_SIZE'(i)) r_regs[i] <= w_wr_data;
    end
  end

  assign din_ready     = (r_state == S_LOAD);
  assign done          = (r_state == S_DONE);
  assign branch        = (r_state == S_BRANCH);
  assign branchaddress = branch ? r_ir[ADDR_W-1:0] : '0;
  assign busy          = (r_state != S_FETCH);
  assign carry         = r_carry;

endmodule
